fp16_to_fp8_tile_packer: RTL and testbench
==========================================

Name: fp16_to_fp8_tile_packer

Overview:
- Down-converts one 4x4 FP16 result tile (the tensor-core D tile) into E5M2 FP8 operands, so results can feed the next FP8 GEMM pass as A/B operands.
- Captures a whole tile in one handshake and buffers it.
- Streams the tile out one packed row (4 x FP8) per beat with valid/ready backpressure.
- Rounding is round-to-nearest-even (RNE), with IEEE-style specials handling.

Parameters:
- ROWS, 4, tile rows, i.e. output beats per tile.
- COLS, 4, elements per row, i.e. FP8 lanes per beat.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a tile.
- in_ready  output  1  packer accepts a tile this cycle.
- in_tile  input  16*ROWS*COLS  FP16 elements; element (r,c) sits at bits [16*(COLS*r+c) +: 16].
- out_valid  output  1  out_data holds a valid row.
- out_ready  input  1  consumer accepts the row.
- out_data  output  8*COLS  E5M2 row; column c sits at bits [8*c +: 8].
- out_last  output  1  current beat is row ROWS-1.
- out_ovf  output  1  at least one finite element in this row exceeded the E5M2 range.

Behaviour:
- Reset state (async, rst_n=0): state=IDLE, row_cnt=0, buffer cleared. Outputs: out_valid=0, out_last=0, out_ovf=0, out_data=0, in_ready=1.
- Reset mid-tile discards the tile; no partial rows are emitted after release.
- States: IDLE and BUSY.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: buffer<=in_tile, row_cnt<=0, state->BUSY.
- BUSY:
  - out_valid=1.
  - out_data = conversion of buffer row row_cnt; out_last=(row_cnt==ROWS-1).
  - out_data, out_last and out_ovf are combinational from registered state and hold stable while out_ready=0.
  - out_valid&&out_ready with row_cnt<ROWS-1: row_cnt increments.
  - Last-row handshake: row_cnt<=0.
  - At that same edge, if in_valid is high, the new tile is captured and the block stays BUSY. Otherwise it goes to IDLE.
- in_ready = (state==IDLE) || (state==BUSY && out_last && out_ready). This is a combinational dependency on out_ready and is accepted.
- Latency: a tile accepted at edge T presents row 0 from edge T onward (one cycle after acceptance). Sustained throughput is one tile per ROWS cycles.
- When out_valid=0, out_data=0, out_last=0 and out_ovf=0.
- Conversion, per element (FP16 and E5M2 share bias 15):
  - NaN (exp=31, mant!=0) -> 0x7F; sign is dropped.
  - +/-Inf -> {s,7'h7C}.
  - Otherwise: lsb=mant[8], guard=mant[7], sticky=|mant[6:0]. Increment = guard&(sticky|lsb). mag7 = in[14:8] + increment.
  - Mantissa carry propagates into the exponent, so subnormal-to-normal and normal-to-next-binade transitions fall out of the add.
  - If a finite input gives mag7 >= 7'h7C: overflow. Result = {s,7'h7C} (Inf) and out_ovf=1.
  - FP16 subnormals/zeros round into E5M2 subnormals or zero; the sign is kept (-0 -> 0x80).

Optional Feature:
- Macro FP8_SAT_EN.
- Defined: finite overflow saturates to {s,7'h7B} (+/-57344). out_ovf is still asserted. Inf and NaN inputs still map as above.
- Undefined: overflow produces +/-Inf as specified.

Decomposition:
- Package tc_fp8_pkg holds:
  - FP16 field widths/positions.
  - E5M2 constants: E5M2_INF_MAG=7'h7C, E5M2_MAX_MAG=7'h7B, E5M2_QNAN=8'h7F.
  - State enum {IDLE,BUSY}.
- Sub-module fp16_to_e5m2: purely combinational, one element per instance.
  - Ports: fp16 in, fp8 out, ovf out.
  - Instantiated COLS times on the selected buffer row.
- The top level holds the FSM, row counter, tile buffer and output muxing.

Test Plan:
- Tile of all 0x3C00 with out_ready=1 -> 4 beats of out_data=0x3C3C3C3C, out_last only on beat 4, out_ovf=0.
- RNE checks, lanes 0x3C80, 0x3D80, 0x0180, 0x0001 -> bytes 0x3C (tie to even), 0x3E (tie rounds up), 0x02, 0x00.
- Specials, lanes 0x7BFF, 0xFC00, 0x7E00, 0x8000:
  - Without FP8_SAT_EN -> 0x7C, 0xFC, 0x7F, 0x80 with out_ovf=1.
  - With FP8_SAT_EN -> lane0 = 0x7B and out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles on row 1 -> out_data and out_last stable, in_ready=0. Release -> rows 1..3 follow in order.
- Back-to-back: in_valid held with two tiles, out_ready=1 -> 8 consecutive valid beats, no bubble, second tile captured on the first tile's last-row edge.
- Assert rst_n=0 during row 2 -> outputs zero immediately, in_ready=1. After release the next tile starts at row 0.

Source files
------------

// File: rtl/tc_fp8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : tc_fp8_pkg                                                 |
// | Shared FP16 field layout, E5M2 encodings and packer FSM states.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package tc_fp8_pkg;

  // FP16 field layout
  localparam int FP16_W        = 16;
  localparam int FP16_SIGN_BIT = 15;
  localparam int FP16_EXP_MSB  = 14;
  localparam int FP16_EXP_LSB  = 10;
  localparam int FP16_MANT_W   = 10;
  localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

  // E5M2 encodings (same exponent bias as FP16)
  localparam int E5M2_W = 8;
  localparam logic [6:0] E5M2_INF_MAG = 7'h7C;
  localparam logic [6:0] E5M2_MAX_MAG = 7'h7B;
  localparam logic [7:0] E5M2_QNAN    = 8'h7F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_to_e5m2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fp16_to_e5m2                                                |
// | Combinational FP16 -> E5M2 conversion with round-to-nearest-even.    |
// | Build option FP8_SAT_EN: finite overflow saturates to +/-57344.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fp16_to_e5m2
  import tc_fp8_pkg::*;
(
  input  logic [FP16_W-1:0] fp16,
  output logic [E5M2_W-1:0] fp8,
  output logic              ovf
);

  logic       sign;
  logic [4:0] exp_f;
  logic [8:0] low;
  logic       is_nan;
  logic       is_inf;
  logic       inc;
  logic [7:0] mag;

  assign sign   = fp16[FP16_SIGN_BIT];
  assign exp_f  = fp16[FP16_EXP_MSB:FP16_EXP_LSB];
  assign low    = fp16[8:0];
  assign is_nan = (exp_f == FP16_EXP_MAX) && (fp16[FP16_MANT_W-1:0] != '0);
  assign is_inf = (exp_f == FP16_EXP_MAX) && (fp16[FP16_MANT_W-1:0] == '0);

  // RNE on the 8 dropped mantissa bits; a carry out of the kept mantissa
  // walks into the exponent field naturally, covering binade transitions.
  assign inc = low[7] & ((|low[6:0]) | low[8]);
  assign mag = {1'b0, fp16[FP16_EXP_MSB:8]} + {7'b0, inc};

  // Select special encodings, overflow handling or the rounded magnitude
  always_comb begin
    fp8 = {sign, mag[6:0]};
    ovf = 1'b0;
    if (is_nan) begin
      fp8 = E5M2_QNAN;
    end else if (is_inf) begin
      fp8 = {sign, E5M2_INF_MAG};
    end else if (mag >= {1'b0, E5M2_INF_MAG}) begin
      ovf = 1'b1;
`ifdef FP8_SAT_EN
      fp8 = {sign, E5M2_MAX_MAG};
`else
      fp8 = {sign, E5M2_INF_MAG};
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp16_to_fp8_tile_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fp16_to_fp8_tile_packer                                     |
// | Buffers a ROWSxCOLS FP16 tile and streams it out as packed E5M2      |
// | rows, one row per valid/ready beat.                                  |
// | Build option FP8_SAT_EN: finite overflow saturates instead of Inf.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fp16_to_fp8_tile_packer
  import tc_fp8_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*ROWS*COLS-1:0]    in_tile,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*COLS-1:0]          out_data,
  output logic                       out_last,
  output logic                       out_ovf
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROW_W = 16 * COLS;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          row_cnt;
  logic [CNT_W-1:0]          row_cnt_nxt;
  logic [16*ROWS*COLS-1:0]   buffer;
  logic [ROW_W-1:0]          row_sel;
  logic [8*COLS-1:0]         row_fp8;
  logic [COLS-1:0]           row_ovf;
  logic                      capture;

  assign row_sel = buffer[int'(row_cnt) * ROW_W +: ROW_W];

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_lane
      fp16_to_e5m2 u_cvt (
        .fp16 (row_sel[16*c +: 16]),
        .fp8  (row_fp8[8*c +: 8]),
        .ovf  (row_ovf[c])
      );
    end
  endgenerate

  // Next-state, row advance and output gating; the last-row handshake can
  // capture the following tile in the same edge so there is no bubble.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    capture     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    out_ovf     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture     = 1'b1;
          row_cnt_nxt = '0;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        out_data  = row_fp8;
        out_last  = (row_cnt == LAST_ROW);
        out_ovf   = |row_ovf;
        in_ready  = out_last && out_ready;
        if (out_ready) begin
          if (!out_last) begin
            row_cnt_nxt = row_cnt + 1'b1;
          end else begin
            row_cnt_nxt = '0;
            if (in_valid) begin
              capture = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, row counter and tile buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      buffer  <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      if (capture) begin
        buffer <= in_tile;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp16_to_fp8_tile_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fp16_to_fp8_tile_packer                                  |
// | Scoreboard bench: expected rows queued on tile acceptance, popped by |
// | an independent monitor on every output handshake.                    |
// | Build option FP8_SAT_EN selects the saturating reference model.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_fp16_to_fp8_tile_packer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int TW   = 16 * ROWS * COLS;

  typedef struct packed {
    logic [8*COLS-1:0] data;
    logic              last;
    logic              ovf;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [TW-1:0]     in_tile = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [8*COLS-1:0] out_data;
  logic              out_last;
  logic              out_ovf;

  beat_t  sb[$];
  int     checks = 0;
  int     failures = 0;
  int     beats = 0;
  longint cyc = 0;
  bit     rand_rdy = 1'b0;

  fp16_to_fp8_tile_packer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tile   (in_tile),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Cycle counter used for throughput checks
  always @(posedge clk) cyc <= cyc + 1;

  // Magnitude of E5M2 code k (0..0x7B) in units of 2^-24
  function automatic longint fp8_val(input int k);
    int e;
    int mm;
    e  = k >> 2;
    mm = k & 3;
    if (e == 0) return longint'(mm) << 8;
    return longint'(4 + mm) << (e + 7);
  endfunction

  // Reference conversion: {ovf, byte}. Finds the nearest representable
  // E5M2 value by search, ties to the even code.
  function automatic logic [8:0] ref_cvt(input logic [15:0] h);
    logic   s;
    int     e;
    int     mt;
    longint m;
    longint d;
    longint best_d;
    int     best;
    s  = h[15];
    e  = int'(h[14:10]);
    mt = int'(h[9:0]);
    if (e == 31) begin
      if (mt != 0) return {1'b0, 8'h7F};
      return {1'b0, s, 7'h7C};
    end
    m = (e == 0) ? longint'(mt) : (longint'(1024 + mt) << (e - 1));
    // Halfway between 57344 and 65536; the tie rounds to the even code 0x7C
    if (m >= (longint'(61440) << 24)) begin
`ifdef FP8_SAT_EN
      return {1'b1, s, 7'h7B};
`else
      return {1'b1, s, 7'h7C};
`endif
    end
    best   = 0;
    best_d = m;
    for (int k = 1; k < 124; k++) begin
      d = m - fp8_val(k);
      if (d < 0) d = -d;
      if ((d < best_d) || ((d == best_d) && (k[0] == 1'b0) && (best[0] == 1'b1))) begin
        best   = k;
        best_d = d;
      end
    end
    return {1'b0, s, best[6:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  task automatic push_tile(input logic [TW-1:0] t);
    beat_t      b;
    logic [8:0] x;
    for (int r = 0; r < ROWS; r++) begin
      b.data = '0;
      b.ovf  = 1'b0;
      b.last = (r == ROWS - 1);
      for (int c = 0; c < COLS; c++) begin
        x = ref_cvt(t[16*(COLS*r + c) +: 16]);
        b.data[8*c +: 8] = x[7:0];
        b.ovf = b.ovf | x[8];
      end
      sb.push_back(b);
    end
  endtask

  // Advance one cycle; inputs only change just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_tile(input logic [TW-1:0] t, output longint acc_cyc);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    acc_cyc = -1;
    in_tile  = t;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        push_tile(t);
      end
      step();
      n++;
      if (!acc && n > 300) begin
        fail_now("tile_accept_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target) begin
      step();
      n++;
      if (n > 500) begin
        fail_now("beat_timeout");
        break;
      end
    end
  endtask

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    logic [15:0]   v;
    for (int i = 0; i < ROWS * COLS; i++) begin
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v;
        1: v = {v[15], 5'd30, v[9:0]};
        2: v = {v[15:8], 8'h80};
        default: v = {v[15], 5'd0, v[9:0]};
      endcase
      t[16*i +: 16] = v;
    end
    return t;
  endfunction

  // Monitor: compare every output handshake against the scoreboard head
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = sb.pop_front();
          chk("beat_data", 64'(out_data), 64'(e.data));
          chk("beat_last", 64'(out_last), 64'(e.last));
          chk("beat_ovf",  64'(out_ovf),  64'(e.ovf));
        end
        beats++;
      end else if (!out_valid) begin
        chk("idle_zero", 64'({out_data, out_last, out_ovf}), 64'd0);
      end
    end
  end

  // Stimulus
  initial begin
    longint        ca;
    longint        cb;
    int            b0;
    beat_t         hold;
    logic [TW-1:0] t;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_outputs",   64'({out_data, out_last, out_ovf}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // All 1.0 tile, consumer always ready
    out_ready = 1'b1;
    b0 = beats;
    send_tile({(ROWS*COLS){16'h3C00}}, ca);
    @(negedge clk);
    chk("ones_row_literal", 64'(out_data), 64'h3C3C3C3C);
    wait_beats(b0 + ROWS);

    // RNE lanes in row 0, specials in row 1, checked against literal bytes
    step();
    out_ready = 1'b0;
    t = rand_tile();
    t[0 +: 64]  = {16'h0001, 16'h0180, 16'h3D80, 16'h3C80};
    t[64 +: 64] = {16'h8000, 16'h7E00, 16'hFC00, 16'h7BFF};
    b0 = beats;
    send_tile(t, ca);
    @(negedge clk);
    chk("rne_row_literal", 64'(out_data), 64'h00023E3C);
    chk("rne_row_ovf",     64'(out_ovf),  64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_beats(b0 + 1);
    out_ready = 1'b0;
    @(negedge clk);
`ifdef FP8_SAT_EN
    chk("special_row_literal", 64'(out_data), 64'h807FFC7B);
`else
    chk("special_row_literal", 64'(out_data), 64'h807FFC7C);
`endif
    chk("special_row_ovf", 64'(out_ovf), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_beats(b0 + ROWS);

    // Backpressure: stall row 1 for five cycles
    b0 = beats;
    send_tile(rand_tile(), ca);
    wait_beats(b0 + 1);
    out_ready = 1'b0;
    hold = sb[0];
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid",    64'(out_valid), 64'd1);
      chk("stall_data",     64'(out_data),  64'(hold.data));
      chk("stall_last",     64'(out_last),  64'd0);
      chk("stall_in_ready", 64'(in_ready),  64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_beats(b0 + ROWS);

    // Back-to-back tiles: second captured on the first tile's last beat
    b0 = beats;
    send_tile(rand_tile(), ca);
    send_tile(rand_tile(), cb);
    chk("b2b_accept_spacing", 64'(cb - ca), 64'(ROWS));
    wait_beats(b0 + 2 * ROWS);

    // Reset during row 2 discards the tile
    b0 = beats;
    send_tile(rand_tile(), ca);
    wait_beats(b0 + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs",   64'({out_data, out_last, out_ovf}), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    b0 = beats;
    send_tile(rand_tile(), ca);
    @(negedge clk);
    chk("post_rst_first_last", 64'(out_last), 64'd0);
    wait_beats(b0 + ROWS);

    // Randomized tiles with random consumer stalls and producer gaps
    rand_rdy = 1'b1;
    repeat (30) begin
      repeat ($urandom_range(0, 2)) step();
      send_tile(rand_tile(), ca);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
        step();
        n++;
      end
    end
    step();
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
